// File: rtl/alu_retire_stage.sv
// Retire stage behind the 16-bit ALU: 2-entry skid buffer, flag register, branch resolution.
// Optional ALU_STALL_CNT_EN adds a saturating upstream stall counter on port stall_cnt.
module alu_retire_stage #(
    parameter int DW    = 16,
    parameter int RW    = 4,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] alu_out,
    input  logic [2:0]    alu_flags,
    input  logic          set_flags,
    input  logic          wr_en,
    input  logic [RW-1:0] dst,
    input  logic          is_branch,
    input  logic [2:0]    cond,
    input  logic [DW-1:0] target,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          wb_en,
    output logic [RW-1:0] wb_dst,
    output logic [DW-1:0] wb_data,
    output logic          br_taken,
    output logic [DW-1:0] br_target,
    output logic [2:0]    flags_q,
    output logic [1:0]    dbg_state_o
`ifdef ALU_STALL_CNT_EN
    ,
    output logic [15:0]   stall_cnt
`endif
);

    // Handshakes: a beat transfers on a rising edge where valid & ready are both high;
    // valid never waits on ready, and in_ready is decoded from occupancy alone.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [2:0]    flags;
        logic          set_flags;
        logic          wr_en;
        logic [RW-1:0] dst;
        logic          is_branch;
        logic [2:0]    cond;
        logic [DW-1:0] target;
    } entry_t;

    state_t state_q;
    entry_t mem_q [DEPTH];
    logic   rd_ptr_q;
    logic   wr_ptr_q;
    entry_t head;
    entry_t in_entry;
    logic   accept;
    logic   retire;

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid & in_ready;
    assign retire    = out_valid & out_ready;
    assign head      = mem_q[rd_ptr_q];

    assign in_entry = '{data: alu_out, flags: alu_flags, set_flags: set_flags, wr_en: wr_en,
                        dst: dst, is_branch: is_branch, cond: cond, target: target};

    // Branch sees flags_q before any update from this same head retiring.
    assign wb_en       = out_valid & head.wr_en;
    assign wb_dst      = head.dst;
    assign wb_data     = head.data;
    assign br_taken    = out_valid & head.is_branch & (|(head.cond & flags_q));
    assign br_target   = head.target;
    assign dbg_state_o = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            flags_q  <= 3'b010;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (retire && head.set_flags) begin
                flags_q <= head.flags;
            end
            // A same-cycle retire still completes; everything else is discarded.
            if (flush) begin
                state_q  <= EMPTY;
                rd_ptr_q <= 1'b0;
                wr_ptr_q <= 1'b0;
            end else begin
                if (accept) begin
                    mem_q[wr_ptr_q] <= in_entry;
                    wr_ptr_q        <= ~wr_ptr_q;
                end
                if (retire) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
                case (state_q)
                    EMPTY: if (accept) state_q <= ONE;
                    ONE: begin
                        if (accept && !retire) state_q <= FULL;
                        else if (!accept && retire) state_q <= EMPTY;
                    end
                    FULL:    if (retire) state_q <= ONE;
                    default: state_q <= EMPTY;
                endcase
            end
        end
    end

`ifdef ALU_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 16'd0;
        end else if (in_valid && !in_ready && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
